frame_buf_ctrl: RTL and testbench
=================================

Name: frame_buf_ctrl

Overview:
- Sequences the game-state to VGA snapshot transfer as a word-serial copy into a double-buffered snapshot RAM.
- The RAM holds 10 obstacle slots and 41 trail slots. The copy runs only during vertical sync, and only after a fresh 60 Hz game update has settled.
- The bank the VGA reads from swaps only when the copy completes. Runs on the 100 MHz system clock, between game logic/map and vga_screen_pic.

Parameters:
- NUM_ENTRIES, 51, words copied per snapshot (addresses 0..NUM_ENTRIES-1).
- ADDR_W, 6, snap_addr width; must satisfy 2**ADDR_W >= NUM_ENTRIES.
- SETTLE_CYCLES, 8, clk cycles to wait after a synchronized game_tick rising edge before data counts as stable (>=1).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n_debounced  input  1  asynchronous, active-low reset
- game_tick  input  1  60 Hz game clock level; asynchronous to clk
- vs  input  1  VGA vertical sync, active-low; asynchronous to clk
- freeze  input  1  synchronous to clk; 1 = hold the current displayed snapshot
- snap_we  output  1  write strobe to the back bank of the snapshot RAM
- snap_addr  output  ADDR_W  entry index being copied
- wr_bank  output  1  bank being written; always ~rd_bank
- rd_bank  output  1  bank the VGA renderer reads
- busy  output  1  high in SETTLE, ARMED or COPY
- abort_pulse  output  1  one-cycle pulse when a copy is cancelled
- frame_cnt  output  CNT_W  completed bank swaps; wraps
- drop_cnt  output  CNT_W  game updates never displayed; saturates at all-ones

Behaviour:
- Clocking and reset
  - clk is the only clock; rst_n_debounced is the asynchronous, active-low reset.
  - Reset values: state=IDLE, snap_we=0, snap_addr=0, rd_bank=0, wr_bank=1, busy=0, abort_pulse=0, frame_cnt=0, drop_cnt=0.
  - Both synchronizer chains reset to 1 for vs and 0 for game_tick.
  - Reset mid-COPY: immediate return to reset values. Partially written back-bank content is never shown because rd_bank is reset.
- Input synchronization and edge detection
  - game_tick and vs each pass through a 2-FF synchronizer, then a registered edge detector.
  - tick_rise = synchronized rising edge of game_tick.
  - vs_fall = synchronized falling edge of vs (start of vsync).
  - vs_low = synchronized level of vs is 0.
- IDLE
  - tick_rise and freeze=0: load the settle counter with SETTLE_CYCLES and go to SETTLE.
  - tick_rise with freeze=1: ignored; no counter change.
- SETTLE
  - Counter decrements each cycle; on reaching 0, go to ARMED.
  - Another tick_rise while in SETTLE: reload the counter and increment drop_cnt.
- ARMED
  - Waits for vs_fall. A vsync already in progress on arrival is not used.
  - tick_rise while in ARMED: increment drop_cnt and go to SETTLE with a reloaded counter.
  - vs_fall: go to COPY with snap_addr=0.
- COPY
  - snap_we=1 every cycle; snap_addr increments 0,1,..,NUM_ENTRIES-1.
  - Exactly NUM_ENTRIES consecutive write cycles; snap_addr never exceeds NUM_ENTRIES-1.
  - After the last write, go to SWAP.
  - vs_low deasserts before the last write: abort. Set snap_we=0 and abort_pulse=1 for one cycle, increment drop_cnt, go to ARMED (retry at the next vsync). rd_bank is unchanged.
  - tick_rise during COPY is ignored. The copy completes with the data it started from.
- SWAP (one cycle)
  - rd_bank toggles (wr_bank follows), frame_cnt increments, snap_addr returns to 0, go to IDLE.
- Latency: vs falls at the pin, is first sampled at clk edge k, and snap_we is high in the cycle starting at edge k+3.
- freeze=1 in SETTLE or ARMED: return to IDLE. drop_cnt is unchanged.
- freeze=1 in COPY: no effect; the copy and swap complete.
- Counter arithmetic: all counters are unsigned.
  - frame_cnt wraps from 2**CNT_W-1 to 0.
  - drop_cnt holds at all-ones.
- Simultaneous events:
  - tick_rise in the same cycle as the SETTLE counter reaching 0: the reload wins (stay in SETTLE, drop counted).
  - tick_rise in the same cycle as vs_fall in ARMED: COPY wins and the tick is counted as dropped.

Optional Feature:
- Macro FRAME_STATS_EN.
- When defined: frame_cnt and drop_cnt behave as described above.
- When undefined: both are tied to 0 and their counter logic is removed. All other behaviour is identical.

Test Plan:
- Reset release, then one game_tick rise, SETTLE_CYCLES=8, then vs falls and stays low for 3200 cycles -> 51 consecutive snap_we cycles with addr 0..50; rd_bank goes 0->1; frame_cnt=1; drop_cnt=0.
- Three game_tick rises with no vs activity, then a vsync -> drop_cnt=2; exactly one 51-word copy; frame_cnt=1.
- vs returns high 20 cycles after the copy starts -> snap_we drops; abort_pulse is high for one cycle; rd_bank unchanged; drop_cnt=1. The next vsync completes the copy and toggles rd_bank.
- freeze=1 held, then a game_tick rise and a vsync -> no snap_we and no rd_bank change. freeze=1 asserted mid-COPY -> the copy completes and rd_bank toggles.
- Assert rst_n_debounced low at COPY address 30 -> snap_we=0, snap_addr=0 and rd_bank=0 immediately, without waiting for a clk edge.
- 300 normal frames (FRAME_STATS_EN defined) -> frame_cnt=44 (wrapped). With FRAME_STATS_EN undefined, frame_cnt=0 and drop_cnt=0 throughout.

Source files
------------

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: copies the game-state snapshot word by word into the back
// bank of a double-buffered snapshot RAM during vsync, then swaps banks.
// Optional statistics counters (frame_cnt, drop_cnt) are built only when the
// macro FRAME_STATS_EN is defined; otherwise both outputs are tied to zero.
module frame_buf_ctrl #(
   parameter int unsigned NUM_ENTRIES   = 51,
   parameter int unsigned ADDR_W        = 6,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n_debounced,
   input  logic              game_tick,
   input  logic              vs,
   input  logic              freeze,
   output logic              snap_we,
   output logic [ADDR_W-1:0] snap_addr,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              busy,
   output logic              abort_pulse,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, ARMED, COPY, SWAP} state_t;

   state_t            state, state_nxt;
   logic [SET_W-1:0]  settle_cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              rd_nxt;
   logic              drop_inc, frame_inc;

   logic [1:0] tick_s, vs_s;
   logic       tick_d, vs_d;
   logic       tick_rise, vs_fall;
   logic       vs_low;

   // Two-stage synchronizers plus registered edge detectors for the async inputs
   always_ff @(posedge clk or negedge rst_n_debounced) begin
      if (!rst_n_debounced) begin
         tick_s    <= '0;
         tick_d    <= 1'b0;
         tick_rise <= 1'b0;
         vs_s      <= '1;
         vs_d      <= 1'b1;
         vs_fall   <= 1'b0;
      end else begin
         tick_s    <= {tick_s[0], game_tick};
         tick_d    <= tick_s[1];
         tick_rise <= tick_s[1] & ~tick_d;
         vs_s      <= {vs_s[0], vs};
         vs_d      <= vs_s[1];
         vs_fall   <= vs_d & ~vs_s[1];
      end
   end

   // vs_d is the level aligned with the registered vs_fall pulse
   assign vs_low  = ~vs_d;
   assign wr_bank = ~rd_bank;
   assign busy    = (state == SETTLE) || (state == ARMED) || (state == COPY);

   // State, settle counter, copy address and read-bank registers
   always_ff @(posedge clk or negedge rst_n_debounced) begin
      if (!rst_n_debounced) begin
         state      <= IDLE;
         settle_cnt <= '0;
         snap_addr  <= '0;
         rd_bank    <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= cnt_nxt;
         snap_addr  <= addr_nxt;
         rd_bank    <= rd_nxt;
      end
   end

   // Next-state logic, write strobe, abort pulse and statistics events
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = settle_cnt;
      addr_nxt    = snap_addr;
      rd_nxt      = rd_bank;
      drop_inc    = 1'b0;
      frame_inc   = 1'b0;
      snap_we     = 1'b0;
      abort_pulse = 1'b0;
      case (state)
         IDLE: begin
            if (tick_rise && !freeze) begin
               state_nxt = SETTLE;
               cnt_nxt   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (freeze) begin
               state_nxt = IDLE;
            end else if (tick_rise) begin
               cnt_nxt  = SETTLE_LOAD;
               drop_inc = 1'b1;
            end else if (settle_cnt <= SET_W'(1)) begin
               cnt_nxt   = '0;
               state_nxt = ARMED;
            end else begin
               cnt_nxt = settle_cnt - SET_W'(1);
            end
         end
         ARMED: begin
            if (freeze) begin
               state_nxt = IDLE;
            end else if (vs_fall) begin
               state_nxt = COPY;
               addr_nxt  = '0;
               drop_inc  = tick_rise;
            end else if (tick_rise) begin
               state_nxt = SETTLE;
               cnt_nxt   = SETTLE_LOAD;
               drop_inc  = 1'b1;
            end
         end
         COPY: begin
            if (!vs_low) begin
               abort_pulse = 1'b1;
               drop_inc    = 1'b1;
               addr_nxt    = '0;
               state_nxt   = ARMED;
            end else begin
               snap_we = 1'b1;
               if (snap_addr == LAST_ADDR) state_nxt = SWAP;
               else                        addr_nxt  = snap_addr + ADDR_W'(1);
            end
         end
         SWAP: begin
            rd_nxt    = ~rd_bank;
            frame_inc = 1'b1;
            addr_nxt  = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FRAME_STATS_EN
   logic [CNT_W-1:0] frame_q, drop_q;

   // Completed-swap counter wraps; dropped-update counter saturates
   always_ff @(posedge clk or negedge rst_n_debounced) begin
      if (!rst_n_debounced) begin
         frame_q <= '0;
         drop_q  <= '0;
      end else begin
         if (frame_inc) frame_q <= frame_q + CNT_W'(1);
         if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      end
   end

   assign frame_cnt = frame_q;
   assign drop_cnt  = drop_q;
`else
   logic unused_stats;
   assign unused_stats = drop_inc ^ frame_inc;
   assign frame_cnt    = '0;
   assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// tb_frame_buf_ctrl: directed plus randomized checks of frame_buf_ctrl against
// a transaction-level model (copies, aborts, drops, bank toggles).
module tb_frame_buf_ctrl;

   localparam int unsigned N  = 51;
   localparam int unsigned AW = 6;
   localparam int unsigned CW = 8;
`ifdef FRAME_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n_debounced, game_tick, vs, freeze;
   logic          snap_we, wr_bank, rd_bank, busy, abort_pulse;
   logic [AW-1:0] snap_addr;
   logic [CW-1:0] frame_cnt, drop_cnt;

   always #5 clk = ~clk;

   frame_buf_ctrl #(
      .NUM_ENTRIES(N), .ADDR_W(AW), .SETTLE_CYCLES(8), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n_debounced(rst_n_debounced), .game_tick(game_tick),
      .vs(vs), .freeze(freeze), .snap_we(snap_we), .snap_addr(snap_addr),
      .wr_bank(wr_bank), .rd_bank(rd_bank), .busy(busy),
      .abort_pulse(abort_pulse), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Monitor state
   int   wr_idx = 0, bursts = 0, last_len = 0, aborts = 0;
   logic prev_abort = 1'b0;

   // Reference model state
   int   exp_frames = 0, exp_drop = 0;
   logic exp_rd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      game_tick = 1'b1; step(3);
      game_tick = 1'b0; step(3);
   endtask

   task automatic vsync(input int len);
      vs = 1'b0; step(len);
      vs = 1'b1; step(6);
   endtask

   task automatic add_drop(input int n);
      exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
   endtask

   task automatic complete_frame();
      exp_frames++;
      exp_rd = ~exp_rd;
   endtask

   task automatic check_model(input string tag);
      logic exp_wr;
      exp_wr = ~exp_rd;
      chk({tag, "_rd_bank"}, rd_bank, exp_rd);
      chk({tag, "_wr_bank"}, wr_bank, exp_wr);
      chk({tag, "_frame_cnt"}, frame_cnt, STATS ? (exp_frames % 256) : 0);
      chk({tag, "_drop_cnt"}, drop_cnt, STATS ? exp_drop : 0);
   endtask

   // Write-burst monitor: address sequence, burst length, abort pulse width
   always @(negedge clk) begin
      if (snap_we) begin
         chk("addr_seq", snap_addr, wr_idx);
         wr_idx++;
      end else if (wr_idx > 0) begin
         last_len = wr_idx;
         bursts++;
         wr_idx = 0;
      end
      if (abort_pulse) begin
         aborts++;
         chk("abort_width", prev_abort, 0);
      end
      prev_abort = abort_pulse;
   end

   initial begin
      int base, base_ab, n, lat;
      rst_n_debounced = 1'b1;
      game_tick = 1'b0; vs = 1'b1; freeze = 1'b0;
      #2 rst_n_debounced = 1'b0;
      step(3);
      chk("rst_snap_we", snap_we, 0);
      chk("rst_snap_addr", snap_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_abort", abort_pulse, 0);
      check_model("rst");
      rst_n_debounced = 1'b1;
      step(3);

      // Single update then a long vsync
      base = bursts;
      pulse_tick(); step(20);
      chk("t1_busy_armed", busy, 1);
      vs = 1'b0;
      @(posedge clk);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (snap_we) begin lat = i; break; end
      end
      chk("t1_vs_to_we_latency", lat, 4);
      step(3200);
      vs = 1'b1; step(6);
      complete_frame();
      chk("t1_bursts", bursts - base, 1);
      chk("t1_len", last_len, N);
      chk("t1_busy_idle", busy, 0);
      check_model("t1");

      // Three updates before one vsync: two dropped
      base = bursts;
      for (int i = 0; i < 3; i++) pulse_tick();
      step(20);
      vsync(60);
      add_drop(2); complete_frame();
      chk("t2_bursts", bursts - base, 1);
      chk("t2_len", last_len, N);
      check_model("t2");

      // vsync too short: abort, then retry at the next vsync
      base = bursts; base_ab = aborts;
      pulse_tick(); step(20);
      vsync(23);
      add_drop(1);
      chk("t3_aborts", aborts - base_ab, 1);
      chk("t3_bursts", bursts - base, 1);
      chk("t3_partial", (last_len < N) ? 1 : 0, 1);
      check_model("t3_abort");
      vsync(60);
      complete_frame();
      chk("t3_retry_len", last_len, N);
      check_model("t3_retry");

      // freeze held: update and vsync are ignored
      base = bursts;
      freeze = 1'b1;
      pulse_tick(); step(20);
      vsync(60);
      chk("t4_no_copy", bursts - base, 0);
      chk("t4_busy", busy, 0);
      check_model("t4_frozen");
      // freeze raised mid-copy: copy and swap still complete
      freeze = 1'b0;
      pulse_tick(); step(20);
      vs = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (snap_we) begin n = 1; break; end
      end
      chk("t4_copy_started", n, 1);
      freeze = 1'b1;
      step(60);
      vs = 1'b1; step(6);
      freeze = 1'b0;
      complete_frame();
      chk("t4_len", last_len, N);
      check_model("t4_midcopy");

      // Asynchronous reset at copy address 30
      pulse_tick(); step(20);
      vs = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (snap_we && snap_addr == AW'(30)) begin n = 1; break; end
      end
      chk("t5_reached_addr30", n, 1);
      rst_n_debounced = 1'b0;
      #1;
      chk("t5_snap_we", snap_we, 0);
      chk("t5_snap_addr", snap_addr, 0);
      chk("t5_rd_bank", rd_bank, 0);
      chk("t5_busy", busy, 0);
      exp_rd = 1'b0; exp_frames = 0; exp_drop = 0;
      vs = 1'b1; step(3);
      rst_n_debounced = 1'b1; step(5);
      check_model("t5");

      // 300 randomized frames: random extra updates and occasional aborts
      base = bursts;
      for (int f = 0; f < 300; f++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) pulse_tick();
         step(20);
         add_drop(n - 1);
         if ($urandom_range(0, 3) == 0) begin
            vsync($urandom_range(8, 40));
            add_drop(1);
         end
         vsync(60);
         complete_frame();
         chk("t6_rd_bank", rd_bank, exp_rd);
         chk("t6_len", last_len, N);
      end
      check_model("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
